// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling text display controller.
package scroll_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SCROLL} scroll_state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/tick_gen.sv
// Scroll-rate tick generator: counts 0 .. TICK_DIV-1 and pulses tick on the wrap cycle.
module tick_gen #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/scroll_text_ctrl.sv
// Buffers a message over valid/ready and scrolls it right-to-left across NUM_DIGITS positions.
// Define SCROLL_LOOP_EN to repeat the pass indefinitely instead of returning to IDLE.
module scroll_text_ctrl
   import scroll_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned MSG_DEPTH  = 32,
   parameter int unsigned TICK_DIV   = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [7:0]              wr_char,
   input  logic                    wr_last,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic [8*NUM_DIGITS-1:0] char_out
);

   localparam int unsigned AW = $clog2(MSG_DEPTH);
   localparam int unsigned LW = $clog2(MSG_DEPTH + 1);
   localparam int unsigned PW = $clog2(MSG_DEPTH + NUM_DIGITS);

   scroll_state_t          state_q;
   logic [LW-1:0]          len_q;
   logic [PW-1:0]          pos_q;
   logic [7:0]             msg_buf [MSG_DEPTH];
   logic [8*NUM_DIGITS-1:0] frame;
   logic                   wr_en;
   logic                   wr_final;
   logic                   last_pos;
   logic                   tick;

   assign wr_ready = (state_q != SCROLL);
   assign wr_en    = wr_valid && wr_ready && !abort;
   // The MSG_DEPTH-th character terminates the message even without wr_last.
   assign wr_final = wr_en && (wr_last || (len_q == LW'(MSG_DEPTH - 1)));
   assign last_pos = (int'(pos_q) == int'(len_q) + int'(NUM_DIGITS) - 1);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort || wr_final),
      .tick  (tick)
   );

   // Digit i shows msg_buf[pos-(NUM_DIGITS-1)+i] when that index lies inside the message.
   always_comb begin
      frame = {NUM_DIGITS{ASCII_SPACE}};
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (state_q == SCROLL &&
             (int'(pos_q) + i >= int'(NUM_DIGITS) - 1) &&
             (int'(pos_q) + i < int'(len_q) + int'(NUM_DIGITS) - 1)) begin
            frame[8*i +: 8] = msg_buf[AW'(int'(pos_q) + i - int'(NUM_DIGITS) + 1)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         msg_buf[len_q[AW-1:0]] <= wr_char;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         len_q    <= '0;
         pos_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         char_out <= {NUM_DIGITS{ASCII_SPACE}};
      end else begin
         done     <= 1'b0;
         char_out <= frame;
         if (abort) begin
            state_q  <= IDLE;
            len_q    <= '0;
            pos_q    <= '0;
            busy     <= 1'b0;
            char_out <= {NUM_DIGITS{ASCII_SPACE}};
         end else begin
            case (state_q)
               IDLE, LOAD: begin
                  if (wr_en) begin
                     len_q <= len_q + LW'(1);
                     if (wr_final) begin
                        state_q <= SCROLL;
                        busy    <= 1'b1;
                        pos_q   <= '0;
                     end else begin
                        state_q <= LOAD;
                     end
                  end
               end
               SCROLL: begin
                  if (tick) begin
                     if (last_pos) begin
                        done  <= 1'b1;
                        pos_q <= '0;
`ifdef SCROLL_LOOP_EN
                        state_q <= SCROLL;
`else
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        len_q   <= '0;
`endif
                     end else begin
                        pos_q <= pos_q + PW'(1);
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scroll_text_ctrl.sv
// Directed bench for scroll_text_ctrl with a frame scoreboard (NUM_DIGITS=4, TICK_DIV=4).
module tb_scroll_text_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned D = 8;
   localparam int unsigned T = 4;
`ifdef SCROLL_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   localparam logic [8*N-1:0] BLANK = {N{8'h20}};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [7:0]     wr_char = 8'h00;
   logic           wr_last = 1'b0;
   logic           abort = 1'b0;
   logic           busy;
   logic           done;
   logic [8*N-1:0] char_out;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0]     msg[$];
   logic [8*N-1:0] frame_q[$];

   scroll_text_ctrl #(
      .NUM_DIGITS (N),
      .MSG_DEPTH  (D),
      .TICK_DIV   (T)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_char  (wr_char),
      .wr_last  (wr_last),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .char_out (char_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8*N-1:0] frame_of(input int p);
      logic [8*N-1:0] f;
      for (int i = 0; i < int'(N); i++) begin
         int idx = p - (int'(N) - 1) + i;
         f[8*i +: 8] = (idx >= 0 && idx < msg.size()) ? msg[idx] : 8'h20;
      end
      return f;
   endfunction

   task automatic write_char(input logic [7:0] c, input logic last, input logic exp_ready);
      check("wr_ready_before_write", wr_ready, exp_ready);
      wr_valid = 1'b1;
      wr_char  = c;
      wr_last  = last;
      cyc();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      if (exp_ready) msg.push_back(c);
   endtask

   // Called just after the edge that entered SCROLL; pushes the pass frames and checks cycles.
   task automatic run_pass(input int cycles, input logic poke);
      int p_len;
      logic [8*N-1:0] cur;
      logic exp_busy;
      p_len = (msg.size() + int'(N)) * int'(T);
      for (int p = 0; p < msg.size() + int'(N); p++) frame_q.push_back(frame_of(p));
      cur = BLANK;
      check("entry_busy", busy, 1'b1);
      check("entry_wr_ready", wr_ready, 1'b0);
      check("entry_char_out", char_out, BLANK);
      for (int c = 1; c <= cycles; c++) begin
         if (poke) begin
            wr_valid = 1'b1;
            wr_char  = 8'h58;
            wr_last  = 1'b1;
         end
         cyc();
         if ((c - 1) % int'(T) == 0) begin
            cur = frame_q.pop_front();
            if (LOOP) frame_q.push_back(cur);
         end
         exp_busy = LOOP ? 1'b1 : (c < p_len);
         check("frame", char_out, cur);
         check("done", done, (c % p_len) == 0);
         check("busy", busy, exp_busy);
         check("wr_ready", wr_ready, !exp_busy);
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   task automatic clear_all();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      msg.delete();
      frame_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_char_out"}, char_out, BLANK);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_wr_ready"}, wr_ready, 1'b1);
   endtask

   initial begin
      // Reset
      repeat (3) cyc();
      check_reset_vals("reset");
      rst_n = 1'b1;
      cyc();

      // "HI": six frames, done at cycle 24
      write_char(8'h48, 1'b0, 1'b1);
      write_char(8'h49, 1'b1, 1'b1);
      run_pass(24, 1'b0);
      clear_all();

      // Depth limit: 8th char ends the message; a 9th during SCROLL is refused
      for (int k = 0; k < int'(D); k++) write_char(8'h41 + 8'(k), 1'b0, 1'b1);
      run_pass((int'(D) + int'(N)) * int'(T), 1'b1);
      clear_all();

      // Abort during frame 3 of "HELLO"
      write_char(8'h48, 1'b0, 1'b1);
      write_char(8'h45, 1'b0, 1'b1);
      write_char(8'h4C, 1'b0, 1'b1);
      write_char(8'h4C, 1'b0, 1'b1);
      write_char(8'h4F, 1'b1, 1'b1);
      run_pass(3 * int'(T) + 1, 1'b0);
      msg.delete();
      frame_q.delete();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_reset_vals("abort");
      for (int c = 0; c < 40; c++) begin
         cyc();
         check("abort_no_done", done, 1'b0);
         check("abort_blank", char_out, BLANK);
      end

      // Write coincident with abort is dropped
      wr_valid = 1'b1;
      wr_char  = 8'h51;
      wr_last  = 1'b1;
      abort    = 1'b1;
      cyc();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      abort    = 1'b0;
      check("abort_write_busy", busy, 1'b0);
      check("abort_write_ready", wr_ready, 1'b1);
      write_char(8'h4F, 1'b0, 1'b1);
      write_char(8'h4B, 1'b1, 1'b1);
      run_pass(24, 1'b0);
      clear_all();

      // Asynchronous reset mid-scroll
      write_char(8'h41, 1'b0, 1'b1);
      write_char(8'h42, 1'b0, 1'b1);
      write_char(8'h43, 1'b1, 1'b1);
      run_pass(10, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      msg.delete();
      frame_q.delete();
      cyc();
      check_reset_vals("reset_held");
      #3;
      rst_n = 1'b1;
      cyc();
      write_char(8'h41, 1'b1, 1'b1);
      run_pass(20, 1'b0);
      clear_all();

`ifdef SCROLL_LOOP_EN
      // Looping: "A" repeats every 5*T cycles
      write_char(8'h41, 1'b1, 1'b1);
      run_pass(3 * 5 * int'(T), 1'b0);
      clear_all();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
